// File: rtl/temp_lm71_scanner.sv
// temp_lm71_scanner: round-robin LM71 reader on a shared SC/SIO bus with
// per-channel temperature, validity, framing error and hysteretic alarm.
module temp_lm71_scanner #(
  parameter int NUM_CH      = 2,
  parameter int CLK_DIV     = 25,
  parameter int IDLE_CYCLES = 5000000,
  parameter int HYST        = 32
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [13:0]            hi_thresh,
  input  logic                   TEMP_SIO,
  output logic                   TEMP_SC,
  output logic [NUM_CH-1:0]      TEMP_CS_n,
  output logic [14*NUM_CH-1:0]   temp_data,
  output logic [NUM_CH-1:0]      valid,
  output logic [NUM_CH-1:0]      frame_err,
  output logic [NUM_CH-1:0]      alarm,
  output logic                   scan_done
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, HOLD} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   cnt;
  logic [IW-1:0]   idle_cnt;
  logic [CW-1:0]   ch;
  logic [3:0]      bits;
  logic            phase;
  logic [15:0]     sr;
  logic            tick, last_ch, good, idle_ready, selected;
  logic signed [14:0] t15, th15, lo15;

  assign tick       = cnt == TW'(CLK_DIV - 1);
  assign last_ch    = ch == CW'(NUM_CH - 1);
  assign idle_ready = idle_cnt == IW'(IDLE_CYCLES);
  assign good       = sr[1:0] == 2'b11;
  assign t15        = {sr[15], sr[15:2]};
  assign th15       = {hi_thresh[13], hi_thresh};
  assign lo15       = th15 - 15'(HYST);
  assign selected   = state == SETUP || state == SHIFT || state == TAIL;
  assign TEMP_SC    = state == SHIFT && phase;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cs
    assign TEMP_CS_n[k] = !(selected && ch == CW'(k));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = idle_ready && enable ? SETUP : IDLE;
      SETUP:   state_nx = tick ? SHIFT : SETUP;
      SHIFT:   state_nx = tick && phase && bits == 4'd15 ? TAIL : SHIFT;
      TAIL:    state_nx = tick ? HOLD : TAIL;
      HOLD:    state_nx = !tick ? HOLD : enable && !last_ch ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idle_cnt  <= '0;
      ch        <= '0;
      bits      <= '0;
      phase     <= 1'b0;
      sr        <= '0;
      temp_data <= '0;
      valid     <= '0;
      frame_err <= '0;
      alarm     <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= state == IDLE || tick ? '0 : cnt + 1'b1;
      idle_cnt  <= state != IDLE ? '0 : idle_ready ? idle_cnt : idle_cnt + 1'b1;
      scan_done <= state == HOLD && tick && enable && last_ch;
      if (state == IDLE)
        ch <= '0;
      else if (state == HOLD && tick && state_nx == SETUP)
        ch <= ch + 1'b1;
      // SIO is captured on the edge that raises SC; bit count advances on the fall
      if (state == SHIFT && tick) begin
        phase <= !phase;
        if (!phase)
          sr <= {sr[14:0], TEMP_SIO};
        else
          bits <= bits + 1'b1;
      end
      if (state == TAIL && tick) begin
        frame_err[ch] <= !good;
        if (good) begin
          temp_data[ch*14 +: 14] <= sr[15:2];
          valid[ch]              <= 1'b1;
          alarm[ch]              <= t15 >= th15 ? 1'b1 : t15 < lo15 ? 1'b0 : alarm[ch];
        end
      end
    end
  end
endmodule

// File: tb/tb_temp_lm71_scanner.sv
// tb_temp_lm71_scanner: directed checks of the LM71 scanner with a two-sensor bus model.
module tb_temp_lm71_scanner;
  localparam int CLK_DIV = 4;
  localparam int IDLE    = 10;

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, sio;
  logic [13:0] hi_thresh = 14'h0320;
  logic        sc, scan_done, all_hi;
  logic [1:0]  cs_n, prev_cs = 2'b11, valid, frame_err, alarm;
  logic [27:0] temp_data;
  logic [15:0] w0 = '0, w1 = '0;
  int nrise = 0, checks = 0, failures = 0, cyc = 0, done_cnt = 0, both_low = 0;
  int lo[2] = '{0, 0}, len[2] = '{0, 0}, rs[2] = '{0, 0}, falls[2] = '{0, 0};
  int fall_cyc[2] = '{0, 0}, rise_cyc[2] = '{0, 0};

  always #10 clk = ~clk;

  temp_lm71_scanner #(.NUM_CH(2), .CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE), .HYST(32)) dut (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .enable(enable), .hi_thresh(hi_thresh),
    .TEMP_SIO(sio), .TEMP_SC(sc), .TEMP_CS_n(cs_n), .temp_data(temp_data),
    .valid(valid), .frame_err(frame_err), .alarm(alarm), .scan_done(scan_done)
  );

  // Sensor model: bit n of the word is presented after the n-th SC rise
  assign all_hi = &cs_n;
  always @(posedge sc or posedge all_hi) begin
    if (all_hi) nrise = 0;
    else nrise = nrise + 1;
  end
  always_comb sio = nrise > 15 ? 1'b0 : !cs_n[0] ? w0[15-nrise] : !cs_n[1] ? w1[15-nrise] : 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (scan_done) done_cnt = done_cnt + 1;
    if (cs_n == 2'b00) both_low = both_low + 1;
    for (int k = 0; k < 2; k++) begin
      if (!cs_n[k]) begin
        lo[k] = lo[k] + 1;
        rs[k] = nrise;
      end
      if (!cs_n[k] && prev_cs[k]) begin
        falls[k] = falls[k] + 1;
        fall_cyc[k] = cyc;
      end
      if (cs_n[k] && !prev_cs[k]) begin
        len[k] = lo[k];
        lo[k] = 0;
        rise_cyc[k] = cyc;
      end
    end
    prev_cs = cs_n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = done_cnt;
    w0 = a;
    w1 = b;
    enable = 1'b1;
    for (int i = 0; i < 400 && done_cnt == d; i++) @(negedge clk);
    enable = 1'b0;
    chk("scan_done_count", done_cnt - d, 1);
    @(negedge clk);
    chk("scan_done_width", scan_done, 0);
  endtask

  initial begin
    int d, f1, k;
    repeat (3) @(negedge clk);
    chk("rst_sc", sc, 0);
    chk("rst_cs", cs_n, 2'b11);
    chk("rst_temp", temp_data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_done", scan_done, 0);
    reset_n = 1'b1;

    run_scan(16'h0C83, 16'hF383);
    chk("scan1_temp", temp_data, {14'h3CE0, 14'h0320});
    chk("scan1_valid", valid, 2'b11);
    chk("scan1_alarm", alarm, 2'b01);
    chk("scan1_ferr", frame_err, 2'b00);
    chk("cs0_low_len", len[0], 136);
    chk("cs1_low_len", len[1], 136);
    chk("sc_rises0", rs[0], 16);
    chk("sc_rises1", rs[1], 16);
    chk("cs_gap", fall_cyc[1] - rise_cyc[0], CLK_DIV);
    chk("both_low", both_low, 0);

    run_scan(16'h0C43, 16'hF383);
    chk("hyst_temp", temp_data[13:0], 14'h0310);
    chk("hyst_hold", alarm, 2'b01);
    run_scan(16'h0BFF, 16'hF383);
    chk("hyst_temp2", temp_data[13:0], 14'h02FF);
    chk("hyst_clear", alarm, 2'b00);

    run_scan(16'h0C80, 16'hF383);
    chk("ferr_flag", frame_err, 2'b01);
    chk("ferr_temp", temp_data, {14'h3CE0, 14'h02FF});
    chk("ferr_valid", valid, 2'b11);

    w0 = 16'h0C83;
    f1 = falls[1];
    d = done_cnt;
    enable = 1'b1;
    for (int i = 0; i < 100 && nrise < 3; i++) @(negedge clk);
    chk("en_reached_shift", nrise >= 3, 1);
    enable = 1'b0;
    for (int i = 0; i < 200 && !cs_n[0]; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    chk("en_drop_temp", temp_data[13:0], 14'h0320);
    chk("en_drop_ferr", frame_err, 2'b00);
    chk("en_drop_ch1", falls[1] - f1, 0);
    chk("en_drop_done", done_cnt - d, 0);
    chk("en_drop_idle", cs_n, 2'b11);

    enable = 1'b1;
    for (int i = 0; i < 100 && nrise < 5; i++) @(negedge clk);
    chk("rst_reached_shift", nrise >= 5, 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_cs", cs_n, 2'b11);
    chk("mrst_sc", sc, 0);
    chk("mrst_temp", temp_data, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_alarm", alarm, 0);
    chk("mrst_done", scan_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    while (cs_n[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("restart_delay", k, IDLE + 1);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    chk("restart_temp", temp_data, {14'h0000, 14'h0320});
    chk("restart_valid", valid, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
